// File: rtl/secuenciador_pkg.sv
// rtl/secuenciador_pkg.sv - shared states, R-type field positions, funct and ALU op codes
package secuenciador_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_MUL = 6'b011000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;

  localparam int OP_HI = 31, OP_LO = 26;
  localparam int RS_HI = 25, RS_LO = 21;
  localparam int RT_HI = 20, RT_LO = 16;
  localparam int RD_HI = 15, RD_LO = 11;
  localparam int SH_HI = 10, SH_LO = 6;
  localparam int FN_HI = 5,  FN_LO = 0;

endpackage

// File: rtl/decodificador_rtype.sv
// rtl/decodificador_rtype.sv - combinational R-type field split and funct-to-ALU-op decode
module decodificador_rtype
  import secuenciador_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [2:0]  alu_op,
  output logic        illegal
);

  logic [2:0] op;
  logic       known;

  always_comb begin
    rs    = instr[RS_HI:RS_LO];
    rt    = instr[RT_HI:RT_LO];
    rd    = instr[RD_HI:RD_LO];
    op    = ALU_AND;
    known = 1'b1;
    case (instr[FN_HI:FN_LO])
      F_ADD:   op = ALU_ADD;
      F_SUB:   op = ALU_SUB;
      F_AND:   op = ALU_AND;
      F_OR:    op = ALU_OR;
      F_MUL:   op = ALU_MUL;
      default: known = 1'b0;
    endcase
    illegal = !(known && (instr[OP_HI:OP_LO] == 6'd0) && (instr[SH_HI:SH_LO] == 5'd0));
    alu_op  = illegal ? ALU_AND : op;
  end

endmodule

// File: rtl/secuenciador_rtype.sv
// rtl/secuenciador_rtype.sv - multi-cycle R-type sequencer with loader/fetch memory arbitration
module secuenciador_rtype
  import secuenciador_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [5:0]        prog_len,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_index,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_reject,
  output logic [ADDR_W-1:0] mem_index,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [4:0]        rf_ra1,
  output logic [4:0]        rf_ra2,
  output logic [4:0]        rf_wa,
  output logic              rf_we,
  output logic [2:0]        alu_op,
  output logic              busy,
  output logic              done,
  output logic              err_illegal
);

  localparam logic [5:0] MAX_LEN = 6'(DEPTH);

  state_t      state;
  logic [5:0]  pc;
  logic [5:0]  len;
  logic [31:0] ir;
  logic        illegal_q;
  logic [5:0]  len_clamped;
  logic [5:0]  pc_next;
  logic        wr_ok;
  logic [4:0]  dec_rs, dec_rt, dec_rd;
  logic [2:0]  dec_op;
  logic        dec_ill;

  decodificador_rtype u_dec (
    .instr   (ir),
    .rs      (dec_rs),
    .rt      (dec_rt),
    .rd      (dec_rd),
    .alu_op  (dec_op),
    .illegal (dec_ill)
  );

  assign len_clamped = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
  assign pc_next     = pc + 6'd1;
  assign busy        = (state == FETCH) || (state == DECODE) || (state == EXEC) || (state == WB);
  assign done        = (state == DONE);
  // The loader owns the memory port only outside a run; fetch owns it in FETCH.
  assign wr_ok       = ld_we && ((state == IDLE) || (state == DONE));

  always_comb begin
    mem_wr    = wr_ok;
    mem_rd    = (state == FETCH);
    mem_index = '0;
    mem_wdata = '0;
    if (wr_ok) begin
      mem_index = ld_index;
      mem_wdata = ld_data;
    end else if (state == FETCH) begin
      mem_index = pc[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      len         <= '0;
      ir          <= '0;
      illegal_q   <= 1'b0;
      rf_ra1      <= '0;
      rf_ra2      <= '0;
      rf_wa       <= '0;
      alu_op      <= ALU_AND;
      rf_we       <= 1'b0;
      err_illegal <= 1'b0;
      ld_reject   <= 1'b0;
    end else begin
      ld_reject <= ld_we && busy;
      rf_we     <= 1'b0;
      case (state)
        IDLE: if (start) begin
          err_illegal <= 1'b0;
          pc          <= '0;
          len         <= len_clamped;
          state       <= (len_clamped == 6'd0) ? DONE : FETCH;
        end
        FETCH: begin
          ir    <= mem_rdata[31:0];
          state <= DECODE;
        end
        DECODE: begin
          rf_ra1    <= dec_rs;
          rf_ra2    <= dec_rt;
          rf_wa     <= dec_rd;
          alu_op    <= dec_op;
          illegal_q <= dec_ill;
          if (dec_ill) err_illegal <= 1'b1;
          state <= EXEC;
        end
        EXEC: begin
          // Registered here so the strobe lines up exactly with the WB cycle.
          rf_we <= !illegal_q;
          state <= WB;
        end
        WB: begin
          pc    <= pc_next;
          state <= (pc_next == len) ? DONE : FETCH;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_rtype.sv
// tb/tb_secuenciador_rtype.sv - scoreboard bench for secuenciador_rtype with a behavioural program model
module tb_secuenciador_rtype;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  prog_len;
  logic        ld_we;
  logic [4:0]  ld_index;
  logic [31:0] ld_data;
  logic        ld_reject;
  logic [4:0]  mem_index;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [4:0]  rf_ra1, rf_ra2, rf_wa;
  logic        rf_we;
  logic [2:0]  alu_op;
  logic        busy, done, err_illegal;

  secuenciador_rtype dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_len(prog_len),
    .ld_we(ld_we), .ld_index(ld_index), .ld_data(ld_data), .ld_reject(ld_reject),
    .mem_index(mem_index), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa(rf_wa),
    .rf_we(rf_we), .alu_op(alu_op), .busy(busy), .done(done), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  always @(posedge clk) if (mem_wr) mem[mem_index] <= mem_wdata;
  assign mem_rdata = mem[mem_index];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct { logic [17:0] v; int c; } ev_t;
  ev_t q_we[$];
  ev_t q_fetch[$];
  int  q_done[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Reference R-type semantics: {legal, alu_op}
  function automatic logic [3:0] ref_decode(input logic [31:0] w);
    logic [2:0] op;
    logic ok;
    ok = 1'b1;
    op = 3'b000;
    case (w[5:0])
      6'h20:   op = 3'b010;
      6'h22:   op = 3'b110;
      6'h24:   op = 3'b000;
      6'h25:   op = 3'b001;
      6'h18:   op = 3'b011;
      default: ok = 1'b0;
    endcase
    if (w[31:26] != 6'd0 || w[10:6] != 5'd0) ok = 1'b0;
    return {ok, ok ? op : 3'b000};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [5:0] fn [5];
    logic [31:0] w;
    int r;
    fn[0] = 6'h20; fn[1] = 6'h22; fn[2] = 6'h24; fn[3] = 6'h25; fn[4] = 6'h18;
    w = {6'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'd0, fn[$urandom_range(0, 4)]};
    r = $urandom_range(0, 9);
    if (r == 0) w[31:26] = 6'($urandom_range(1, 63));
    if (r == 1) w[10:6]  = 5'($urandom_range(1, 31));
    if (r == 2) w[5:0]   = 6'($urandom);
    return w;
  endfunction

  always @(negedge clk) begin : monitor
    ev_t e;
    int  c;
    if (rst_n) begin
      if (busy) check("no_wr_busy", mem_wr, 0);
      if (mem_rd) begin
        if (q_fetch.size() == 0) fail("unexpected_fetch");
        else begin
          e = q_fetch.pop_front();
          check("fetch_idx", mem_index, e.v[4:0]);
          check("fetch_cyc", cyc, e.c);
        end
      end
      if (rf_we) begin
        if (q_we.size() == 0) fail("unexpected_rf_we");
        else begin
          e = q_we.pop_front();
          check("we_fields", {rf_ra1, rf_ra2, rf_wa, alu_op}, e.v);
          check("we_cyc", cyc, e.c);
        end
      end
      if (done) begin
        if (q_done.size() == 0) fail("unexpected_done");
        else begin
          c = q_done.pop_front();
          check("done_cyc", cyc, c);
        end
      end
    end
  end

  task automatic load(input logic [4:0] idx, input logic [31:0] d);
    @(posedge clk); #1;
    ld_we = 1'b1; ld_index = idx; ld_data = d;
    #1;
    check("ld_same_cycle", {mem_wr, mem_rd, mem_index, mem_wdata}, {1'b1, 1'b0, idx, d});
    @(posedge clk); #1;
    ld_we = 1'b0;
    ref_mem[idx] = d;
  endtask

  task automatic run(input int plen, input bit inject);
    int s, n, lim;
    logic [3:0] dr;
    logic [31:0] w;
    bit anyill;
    n = (plen > 32) ? 32 : plen;
    anyill = 1'b0;
    @(posedge clk); #1;
    s = cyc;
    start = 1'b1;
    prog_len = 6'(plen);
    for (int i = 0; i < n; i++) begin
      w  = ref_mem[i];
      dr = ref_decode(w);
      q_fetch.push_back('{v: 18'(i), c: s + 1 + 4 * i});
      if (dr[3]) q_we.push_back('{v: {w[25:21], w[20:16], w[15:11], dr[2:0]}, c: s + 4 * (i + 1)});
      else anyill = 1'b1;
    end
    q_done.push_back(s + 4 * n + 1);
    @(posedge clk); #1;
    start = 1'b0;
    check("err_cleared_by_start", err_illegal, 0);
    if (inject && n > 0) begin
      ld_we = 1'b1; ld_index = 5'($urandom); ld_data = $urandom;
      #1;
      check("wr_gated_busy", mem_wr, 0);
      @(posedge clk); #1;
      ld_we = 1'b0;
      check("ld_reject", ld_reject, 1);
    end
    lim = 4 * n + 20;
    for (int k = 0; k < lim && (q_done.size() != 0 || q_we.size() != 0 || q_fetch.size() != 0); k++)
      @(posedge clk);
    if (q_done.size() != 0 || q_we.size() != 0 || q_fetch.size() != 0) begin
      fail("run_timeout");
      q_done.delete(); q_we.delete(); q_fetch.delete();
    end
    #1;
    check("err_illegal_end", err_illegal, anyill);
    repeat (3) @(posedge clk);
    #1;
    check("err_illegal_held", err_illegal, anyill);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_outputs", {busy, rf_we, done, err_illegal, mem_rd, mem_wr, ld_reject}, 7'd0);
    q_done.delete(); q_we.delete(); q_fetch.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; prog_len = '0;
    ld_we = 1'b0; ld_index = '0; ld_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {busy, rf_we, done, err_illegal, mem_rd, mem_wr, ld_reject, rf_wa, alu_op}, 15'd0);
    rst_n = 1'b1;

    // Full-depth program: 32 fetches with no wrap, then a clamped length.
    for (int i = 0; i < 32; i++) load(5'(i), rand_word());
    run(32, 1'b0);
    run($urandom_range(33, 63), 1'b0);

    // Three-instruction program.
    load(5'd0, 32'h00221820);
    load(5'd1, 32'h00642822);
    load(5'd2, 32'h00A63824);
    run(3, 1'b0);

    // Illegal word: no write strobe, sticky error, cleared by reset.
    load(5'd0, 32'h8C000000);
    run(1, 1'b0);
    pulse_reset();

    // Reset in the EXEC cycle of the first instruction.
    load(5'd0, 32'h00221820);
    @(posedge clk); #1;
    start = 1'b1; prog_len = 6'd3;
    q_fetch.push_back('{v: 18'd0, c: cyc + 1});
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    pulse_reset();
    repeat (20) @(posedge clk);

    // MUL, empty program, then loader collision during FETCH.
    load(5'd0, 32'h0022C818);
    run(1, 1'b0);
    run(0, 1'b0);
    run(2, 1'b1);

    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) load(5'(i), rand_word());
      run(n, 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 32; i++) check("mem_intact", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/secuenciador_rtype.md
Name: secuenciador_rtype

Overview:
- Multi-cycle sequencer that steps through the 32-entry instruction memory (A_MemoriaA), decodes each R-type word (ADD/SUB/AND/OR/MUL), and drives register-file addresses, ALU op and the write-enable.
- Also arbitrates the memory port between an external program loader (writes while idle) and its own fetch path (reads while running).
- Sits between the program loader and the memory / register-file / ALU datapath.

Parameters:
- ADDR_W, 5, memory index width.
- DATA_W, 32, instruction width.
- DEPTH, 32, number of memory entries; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin executing; sampled in IDLE only.
- prog_len  in  6  number of instructions to run; values 0..32, values >32 clamp to 32.
- ld_we  in  1  loader write request.
- ld_index  in  ADDR_W  loader write address.
- ld_data  in  DATA_W  loader write data.
- ld_reject  out  1  one-cycle pulse: ld_we arrived while busy and was dropped.
- mem_index  out  ADDR_W  to memory index.
- mem_rd  out  1  to memory R_B.
- mem_wr  out  1  to memory w_B.
- mem_wdata  out  DATA_W  to memory DATA.
- mem_rdata  in  DATA_W  from memory DATA_OUT; combinational read.
- rf_ra1  out  5  rs field.
- rf_ra2  out  5  rt field.
- rf_wa  out  5  rd field.
- rf_we  out  1  register-file write strobe.
- alu_op  out  3  ALU operation code.
- busy  out  1  high in FETCH..WB.
- done  out  1  one-cycle pulse at end of program.
- err_illegal  out  1  sticky: an illegal word was encountered.

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE; pc and instruction register are cleared.
  - All outputs go to 0, including err_illegal.
  - Reset mid-program aborts immediately; no rf_we pulse escapes.
- State sequence is IDLE -> FETCH -> DECODE -> EXEC -> WB -> (FETCH or DONE) -> IDLE. Each state lasts exactly 1 cycle.
- IDLE:
  - start=1 with prog_len=0: go to DONE; no memory reads.
  - start=1 with prog_len>0: pc<=0, capture the clamped length, clear err_illegal, go to FETCH.
  - start while busy is ignored.
- FETCH: mem_index=pc, mem_rd=1, mem_wr=0; the instruction register captures mem_rdata at the clock edge.
- DECODE:
  - Register rs/rt/rd onto rf_ra1/rf_ra2/rf_wa; these stay stable through WB.
  - Compute alu_op and illegal.
  - Legal means opcode[31:26]=0, shamt[10:6]=0, and funct is one of:
    - 100000 ADD -> alu_op 010
    - 100010 SUB -> alu_op 110
    - 100100 AND -> alu_op 000
    - 100101 OR -> alu_op 001
    - 011000 MUL -> alu_op 011
  - Any other word is illegal: alu_op=000 and err_illegal is set and stays set until the next start.
- EXEC: outputs held while the ALU settles; rf_we=0.
- WB:
  - rf_we=1 for this cycle only if the instruction is legal.
  - Then pc<=pc+1. If pc+1 equals the length go to DONE, otherwise go to FETCH.
  - pc is 6 bits internally so a length of 32 terminates correctly; mem_index uses pc[4:0].
- DONE: done=1 for one cycle, then IDLE. Last decoded fields remain on the rf_*/alu_op outputs until the next start.
- Throughput and latency: 4 cycles per instruction; a run of N instructions asserts done at cycle 4N+1 after the start cycle.
- Loader arbitration:
  - In IDLE or DONE, ld_we=1 drives mem_wr=1, mem_rd=0, mem_index=ld_index, mem_wdata=ld_data in the same cycle (combinational path).
  - When busy, ld_we is dropped and ld_reject=1 is registered for the next cycle.
  - If start and ld_we arrive in the same IDLE cycle, the write is performed and the run also starts.
- mem_wr is never 1 while busy.

Decomposition:
- Package secuenciador_pkg holds:
  - State enum: IDLE, FETCH, DECODE, EXEC, WB, DONE.
  - Funct constants: F_ADD, F_SUB, F_AND, F_OR, F_MUL.
  - ALU op constants: ALU_AND, ALU_OR, ALU_ADD, ALU_MUL, ALU_SUB.
  - Field bit positions.
- Sub-module decodificador_rtype: purely combinational; instruction in, rs/rt/rd/alu_op/illegal out. Instantiated once.

Test Plan:
- Reset: hold rst_n=0 mid-EXEC -> state IDLE asynchronously; rf_we=0, busy=0, done=0, err_illegal=0; no writes follow.
- Load and run 3 instructions:
  - Loader writes 32'h00221820 (ADD R3=R1+R2) at 0, 32'h00642822 (SUB) at 1, 32'h00A63824 (AND) at 2.
  - Then start with prog_len=3.
  - Expect rf_we pulses with (ra1,ra2,wa,alu_op) = (1,2,3,010), (3,4,5,110), (5,6,7,000), at cycles 4, 8 and 12 after start.
  - Expect done at cycle 13.
- Illegal word: memory[0]=32'h8C000000, prog_len=1 -> no rf_we pulse, err_illegal=1 and held; the next start clears it.
- Boundaries:
  - prog_len=0 -> done on the next cycle with no mem_rd.
  - prog_len=32 -> 32 fetches of index 0..31 with no wrap to 0, done at cycle 129.
- Arbitration: ld_we=1 during FETCH -> mem_wr stays 0, ld_reject=1 the following cycle, memory unchanged. ld_we in IDLE -> mem_wr=1 in the same cycle.
- MUL: 32'h0022C818 (MUL R25=R1*R2) -> alu_op=011, wa=25, rf_we pulsed.
